// File: rtl/dcm_ps_seq_if.sv
// DCM variable phase-shift control bundle: configuration-side request/status
// plus the psen/psincdec/psdone handshake towards the DCM.
interface dcm_ps_seq_if #(
    parameter int unsigned PH_W = 9
);
    logic                   start;
    logic signed [PH_W-1:0] target;
    logic                   rezero;
    logic                   psdone;
    logic                   psen;
    logic                   psincdec;
    logic                   busy;
    logic                   done;
    logic                   err_tmo;
    logic signed [PH_W-1:0] cur_phase;

    // Driver side: configuration registers plus the DCM's psdone
    modport master (
        output start, target, rezero, psdone,
        input  psen, psincdec, busy, done, err_tmo, cur_phase
    );

    // Controller side
    modport slave (
        input  start, target, rezero, psdone,
        output psen, psincdec, busy, done, err_tmo, cur_phase
    );
endinterface

// File: rtl/dcm_ps_seq.sv
// Steps a DCM variable phase shifter one unit at a time towards a clamped
// absolute signed target, tracking the current offset and flagging a lost psdone.
module dcm_ps_seq #(
    parameter int unsigned PH_W     = 9,
    parameter int unsigned PH_LIMIT = 255,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic          clk,
    input  logic          rst,
    dcm_ps_seq_if.slave   ps
);

    localparam int unsigned CNT_W = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic signed [PH_W-1:0] LIM_P    = PH_W'(PH_LIMIT);
    localparam logic signed [PH_W-1:0] LIM_N    = -LIM_P;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_STEP,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e                 state_q;
    logic signed [PH_W-1:0] tgt_q;
    logic signed [PH_W-1:0] cur_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   psen_q;
    logic                   inc_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic signed [PH_W-1:0] tgt_clamp_d;

    // Saturate the requested target into the legal phase window
    always_comb begin
        tgt_clamp_d = ps.target;
        if (ps.target > LIM_P) begin
            tgt_clamp_d = LIM_P;
        end else if (ps.target < LIM_N) begin
            tgt_clamp_d = LIM_N;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            psen_q  <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (ps.rezero) begin
            // DCM was reset underneath us: its phase is back at zero
            state_q <= ST_IDLE;
            cur_q   <= '0;
            psen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ps.start) begin
                        tgt_q   <= tgt_clamp_d;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (cur_q == tgt_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        inc_q   <= (tgt_q > cur_q);
                        psen_q  <= 1'b1;
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    psen_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ps.psdone) begin
                        cur_q   <= inc_q ? (cur_q + PH_W'(1)) : (cur_q - PH_W'(1));
                        state_q <= ST_CMP;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    psen_q  <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps.psen      = psen_q;
    assign ps.psincdec  = inc_q;
    assign ps.busy      = busy_q;
    assign ps.done      = done_q;
    assign ps.err_tmo   = err_q;
    assign ps.cur_phase = cur_q;

endmodule

// File: tb/tb_dcm_ps_seq.sv
// Randomised bench for dcm_ps_seq: a move-level model predicts every output
// cycle by cycle while directed cases pin the model with literal values.
module tb_dcm_ps_seq;

    localparam int unsigned PH_W     = 9;
    localparam int unsigned PH_LIMIT = 4;
    localparam int unsigned TMO_CYC  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcm_ps_seq_if #(.PH_W(PH_W)) bus ();

    dcm_ps_seq #(
        .PH_W    (PH_W),
        .PH_LIMIT(PH_LIMIT),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps (bus.slave)
    );

    // Model state: phase, last direction, sticky error
    int   m_cur;
    logic m_inc;
    logic m_err;

    logic exp_psen, exp_inc, exp_busy, exp_done, exp_err;
    int   exp_cur;
    bit   chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int psen_cnt = 0;
    int done_cnt = 0;
    int mv_cyc;
    int ab_at;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic int clamp(input int t);
        if (t > int'(PH_LIMIT)) return int'(PH_LIMIT);
        if (t < -int'(PH_LIMIT)) return -int'(PH_LIMIT);
        return t;
    endfunction

    // Per-cycle compare against the model's expectation
    always @(negedge clk) begin
        if (chk_en) begin
            chk("psen",      32'(bus.psen),      32'(exp_psen));
            chk("psincdec",  32'(bus.psincdec),  32'(exp_inc));
            chk("busy",      32'(bus.busy),      32'(exp_busy));
            chk("done",      32'(bus.done),      32'(exp_done));
            chk("err_tmo",   32'(bus.err_tmo),   32'(exp_err));
            chk("cur_phase", 32'(bus.cur_phase), 32'(exp_cur));
            if (bus.psen === 1'b1) psen_cnt++;
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic set_exp(input logic p, input logic b, input logic d);
        exp_psen = p;
        exp_busy = b;
        exp_done = d;
        exp_inc  = m_inc;
        exp_err  = m_err;
        exp_cur  = m_cur;
    endtask

    task automatic cyc(input logic pd, input logic st, input int tg, output logic rz);
        rz = (ab_at != 0) && (mv_cyc == ab_at);
        bus.start  = st;
        bus.target = PH_W'(tg);
        bus.psdone = pd;
        bus.rezero = rz;
        @(posedge clk);
        #1;
        mv_cyc++;
        bus.start  = 1'b0;
        bus.psdone = 1'b0;
        bus.rezero = 1'b0;
    endtask

    task automatic do_abort();
        m_cur = 0;
        m_err = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0);
    endtask

    // Cycle while busy outside WAIT: psdone and start are junk the DUT must ignore
    task automatic busy_cyc(input bit noise, output logic rz);
        logic pd;
        pd = noise ? logic'($urandom_range(0, 1)) : 1'b0;
        cyc(pd, noise, int'($urandom_range(0, 30)) - 15, rz);
    endtask

    // One full move request. lat_fix=0 picks a random psdone latency per step;
    // tmo_step selects which step loses its psdone; abort_at fires rezero.
    task automatic move(input int tgt, input int lat_fix, input bit noise,
                        input int tmo_step, input int abort_at);
        int   t_cl;
        int   k;
        int   nstep;
        logic rz;
        logic pd;
        ab_at  = abort_at;
        mv_cyc = 0;
        t_cl   = clamp(tgt);
        cyc(1'b0, 1'b1, tgt, rz);
        m_err = 1'b0;
        set_exp(1'b0, 1'b1, 1'b0);
        nstep = 0;
        while (m_cur != t_cl) begin
            busy_cyc(noise, rz);
            if (rz) begin do_abort(); return; end
            m_inc = (t_cl > m_cur);
            set_exp(1'b1, 1'b1, 1'b0);
            busy_cyc(noise, rz);
            if (rz) begin do_abort(); return; end
            set_exp(1'b0, 1'b1, 1'b0);
            k = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5));
            for (int j = 1; ; j++) begin
                pd = (nstep != tmo_step) && (j == k);
                cyc(pd, noise, int'($urandom_range(0, 30)) - 15, rz);
                if (rz) begin do_abort(); return; end
                if (pd) begin
                    m_cur = m_inc ? m_cur + 1 : m_cur - 1;
                    set_exp(1'b0, 1'b1, 1'b0);
                    break;
                end
                set_exp(1'b0, 1'b1, 1'b0);
                if (j == int'(TMO_CYC)) begin
                    busy_cyc(noise, rz);
                    if (rz) begin do_abort(); return; end
                    m_err = 1'b1;
                    set_exp(1'b0, 1'b0, 1'b0);
                    return;
                end
            end
            nstep++;
        end
        busy_cyc(noise, rz);
        if (rz) begin do_abort(); return; end
        set_exp(1'b0, 1'b1, 1'b1);
        busy_cyc(noise, rz);
        if (rz) begin do_abort(); return; end
        set_exp(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit noise);
        logic rz;
        ab_at = 0;
        for (int i = 0; i < n; i++) begin
            cyc(noise ? logic'($urandom_range(0, 1)) : 1'b0, 1'b0, 0, rz);
            set_exp(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clr_cnt();
        psen_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rz;
        logic [PH_W-1:0] raw;
        int tg;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.target = '0;
        bus.rezero = 1'b0;
        bus.psdone = 1'b0;
        ab_at      = 0;
        mv_cyc     = 0;
        m_cur = 0; m_inc = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_exp(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        rst = 1'b0;
        idle(1, 1'b0);
        chk("reset_cur", 32'(bus.cur_phase), 32'd0);

        // Reset while waiting for psdone
        ab_at = 0; mv_cyc = 0;
        cyc(1'b0, 1'b1, 3, rz);
        set_exp(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, rz);
        m_inc = 1'b1; set_exp(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, rz);
        set_exp(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, rz);
        set_exp(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        m_cur = 0; m_inc = 1'b0; m_err = 1'b0;
        cyc(1'b0, 1'b0, 0, rz);
        set_exp(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, rz);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 0, rz);
        set_exp(1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_late_psdone_cur", 32'(bus.cur_phase), 32'd0);

        // +3 with fixed psdone latency of 4
        clr_cnt();
        move(3, 4, 1'b0, -1, 0);
        idle(1, 1'b0);
        chk("up3_psen_pulses", 32'(psen_cnt), 32'd3);
        chk("up3_done_pulses", 32'(done_cnt), 32'd1);
        chk("up3_cur", 32'(bus.cur_phase), 32'd3);

        // 3 -> -2
        clr_cnt();
        move(-2, 4, 1'b0, -1, 0);
        idle(1, 1'b0);
        raw = bus.cur_phase;
        chk("dn5_psen_pulses", 32'(psen_cnt), 32'd5);
        chk("dn5_done_pulses", 32'(done_cnt), 32'd1);
        chk("dn5_cur_raw", 32'(raw), 32'h1FE);
        chk("dn5_dir", 32'(bus.psincdec), 32'd0);

        // Already there, with starts hammered while busy
        clr_cnt();
        move(-2, 0, 1'b1, -1, 0);
        idle(1, 1'b0);
        chk("same_psen_pulses", 32'(psen_cnt), 32'd0);
        chk("same_done_pulses", 32'(done_cnt), 32'd1);

        // Clamp on both sides after a rezero
        ab_at = 0; mv_cyc = 0;
        bus.rezero = 1'b1;
        @(posedge clk); #1;
        bus.rezero = 1'b0;
        m_cur = 0; m_err = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0);
        clr_cnt();
        move(7, 0, 1'b0, -1, 0);
        idle(1, 1'b0);
        chk("clamp_hi_steps", 32'(psen_cnt), 32'd4);
        chk("clamp_hi_cur", 32'(bus.cur_phase), 32'd4);
        clr_cnt();
        move(-100, 0, 1'b0, -1, 0);
        idle(1, 1'b0);
        chk("clamp_lo_steps", 32'(psen_cnt), 32'd8);
        chk("clamp_lo_cur", 32'(bus.cur_phase), -32'sd4);

        // Lost psdone on the first step
        clr_cnt();
        move(1, 2, 1'b0, 0, 0);
        idle(1, 1'b0);
        chk("tmo_err", 32'(bus.err_tmo), 32'd1);
        chk("tmo_cur", 32'(bus.cur_phase), -32'sd4);
        chk("tmo_done_pulses", 32'(done_cnt), 32'd0);
        chk("tmo_psen_pulses", 32'(psen_cnt), 32'd1);
        move(-4, 0, 1'b0, -1, 0);
        idle(1, 1'b0);
        chk("restart_clears_err", 32'(bus.err_tmo), 32'd0);

        // Rezero in the second WAIT cycle
        clr_cnt();
        move(2, 4, 1'b0, -1, 4);
        idle(2, 1'b0);
        chk("rezero_cur", 32'(bus.cur_phase), 32'd0);
        chk("rezero_busy", 32'(bus.busy), 32'd0);
        chk("rezero_done_pulses", 32'(done_cnt), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) tg = int'($urandom_range(0, 511)) - 256;
            else tg = int'($urandom_range(0, 14)) - 7;
            move(tg, 0, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 25)) : 0);
            idle(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end
        idle(2, 1'b0);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
